add_sched: RTL and testbench
============================

ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL provide parameter SLICE, default 8, adder-chain width processed per cycle; WIDTH SHALL be an integer multiple of SLICE; NSL = WIDTH/SLICE.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk1 input 1, rising-edge clock; rst_n input 1, synchronous reset, active low.
REQ-004 a_valid input 1; requester 0 operation request.
REQ-005 a_ready output 1; requester 0 accept (handshake when a_valid & a_ready).
REQ-006 a_x, a_y input WIDTH each; a_cin input 1; requester 0 operands and carry-in.
REQ-007 b_valid, b_ready, b_x, b_y, b_cin: same as REQ-004..006 for requester 1.
REQ-008 res_valid output 1; result available.
REQ-009 res_ready input 1; consumer accepts result (handshake when res_valid & res_ready).
REQ-010 res_sum output WIDTH; res_cout output 1; res_id output 1 (0 = A, 1 = B).
REQ-011 busy output 1; high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-013 IDLE: a_ready/b_ready SHALL be combinational; only the granted requester's ready is high, and only when it is valid; both low in CALC and DONE.
REQ-014 Arbitration SHALL be round-robin with a last-grant pointer: one valid -> grant it; both valid -> grant the one not granted last; pointer updates only on accept.
REQ-015 On accept: latch x, y, cin, id; slice index <- 0; go to CALC.
REQ-016 CALC: each cycle SHALL add one SLICE-bit slice (LSB slice first) of latched x and y plus the running carry (carry-in for slice 0), writing sum bits into the result register and carry into the running carry.
REQ-017 After slice NSL-1: go to DONE; res_sum = (x + y + cin) mod 2^WIDTH, res_cout = bit WIDTH of that sum.
REQ-018 res_valid SHALL rise exactly NSL cycles after the accepting edge (default 4) and stay high, with res_sum/res_cout/res_id stable, until the res_ready handshake.
REQ-019 DONE with res_ready high: go to IDLE next edge; no new request accepted in the same cycle (min. issue interval NSL+2 cycles).
REQ-020 Requests arriving in CALC/DONE SHALL wait; requesters SHALL hold valid and operands until ready; valid deasserted before accept is dropped with no state effect.
REQ-021 res_ready in IDLE or CALC SHALL be ignored.
REQ-022 Operand changes on a_x/b_x after accept SHALL not affect the in-flight result.

Reset
REQ-023 rst_n low at a rising edge SHALL force IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, slice index=0, running carry=0, pointer=1 (requester 0 wins first tie).
REQ-024 Reset mid-CALC or mid-DONE SHALL abort the operation with no result emitted; both readies low while rst_n low.

Verification
REQ-025 Single add: a_x=0x0000_00FF, a_y=0x0000_0001, a_cin=0 -> accept, res_valid 4 cycles later, res_sum=0x0000_0100, res_cout=0, res_id=0.
REQ-026 Full carry chain: b_x=0xFFFF_FFFF, b_y=0, b_cin=1 -> res_sum=0x0000_0000, res_cout=1, res_id=1.
REQ-027 Contention: a_valid and b_valid high from reset release -> A granted first, then B; alternate thereafter while both stay valid.
REQ-028 Backpressure: hold res_ready=0 for 10 cycles in DONE -> outputs stable, both readies low, no second accept; release -> IDLE next edge.
REQ-029 Reset mid-op: assert rst_n=0 during CALC slice 2 -> next edge all outputs at reset values, no res_valid pulse afterward.
REQ-030 Random: 1000 random operand/cin/valid/res_ready streams -> every result matches x+y+cin, ids in issue order, no lost or duplicated operations.

Source files
------------

// File: rtl/add_sched.sv
// Two-requester, round-robin scheduled adder: one SLICE-bit chunk of the sum is
// produced per cycle, LSB first, and the result is held until the consumer takes it.
module add_sched #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] a_y,
  input  logic             a_cin,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_x,
  input  logic [WIDTH-1:0] b_y,
  input  logic             b_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             res_valid_q;
  logic             busy_q;

  logic             grant_a_s;
  logic             grant_b_s;
  int               lo_s;
  logic [SLICE:0]   slice_s;

  // Round-robin: ptr_q holds the last granted id, so a tie goes to the other one.
  always_comb begin
    grant_a_s = a_valid && (!b_valid || ptr_q);
    grant_b_s = b_valid && (!a_valid || !ptr_q);
    a_ready   = (state_q == IDLE) && rst_n && grant_a_s;
    b_ready   = (state_q == IDLE) && rst_n && grant_b_s;
  end

  // One slice of the ripple chain: latched operands plus the running carry.
  always_comb begin
    lo_s    = int'(idx_q) * SLICE;
    slice_s = {1'b0, x_q[lo_s +: SLICE]} + {1'b0, y_q[lo_s +: SLICE]}
            + {{SLICE{1'b0}}, carry_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (grant_a_s) begin
          x_d     = a_x;
          y_d     = a_y;
          carry_d = a_cin;
          id_d    = 1'b0;
          ptr_d   = 1'b0;
          idx_d   = '0;
          state_d = CALC;
        end else if (grant_b_s) begin
          x_d     = b_x;
          y_d     = b_y;
          carry_d = b_cin;
          id_d    = 1'b1;
          ptr_d   = 1'b1;
          idx_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        sum_d[lo_s +: SLICE] = slice_s[SLICE-1:0];
        carry_d              = slice_s[SLICE];
        if (idx_q == IW'(NSL - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = CALC;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b1;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      res_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res_sum   = sum_q;
  assign res_cout  = carry_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level model.
module tb_add_sched;

  localparam int WIDTH = 32;
  localparam int NSL   = 4;

  logic             clk1;
  logic             rst_n;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [WIDTH-1:0] a_x, a_y, b_x, b_y;
  logic             a_cin, b_cin;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_id, busy;

  int n_vec = 0;
  int n_bad = 0;

  add_sched #(.WIDTH(WIDTH), .SLICE(8)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_cin(a_cin),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_cin(b_cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH-1:0] esum;
    logic             ecout;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
  } res_t;

  vec_t vt[7];
  res_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    int unsigned sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return {WIDTH{1'b1}};
    else if (sel == 1) return '0;
    else return WIDTH'($urandom);
  endfunction

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    a_x = '0; a_y = '0; a_cin = 1'b0;
    b_x = '0; b_y = '0; b_cin = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
  endtask

  // One complete transaction from a single requester, entered at posedge+1.
  task automatic do_op(input vec_t v);
    int w;
    int lat;
    res_ready = 1'b0;
    if (v.id == 1'b0) begin
      a_valid = 1'b1; a_x = v.x; a_y = v.y; a_cin = v.cin;
    end else begin
      b_valid = 1'b1; b_x = v.x; b_y = v.y; b_cin = v.cin;
    end
    #1;
    w = 0;
    while (!(v.id ? b_ready : a_ready) && w < 20) begin
      @(posedge clk1); #1; w++;
    end
    chk("vec ready", 64'(v.id ? b_ready : a_ready), 64'(1));
    @(posedge clk1); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_x = ~v.x; a_y = ~v.y; b_x = ~v.x; b_y = ~v.y;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk1); #1; lat++;
    end
    chk("vec latency", 64'(lat), 64'(NSL));
    chk("vec sum", 64'(res_sum), 64'(v.esum));
    chk("vec cout", 64'(res_cout), 64'(v.ecout));
    chk("vec id", 64'(res_id), 64'(v.id));
    res_ready = 1'b1;
    @(posedge clk1); #1;
    res_ready = 1'b0;
    chk("vec idle after take", 64'({busy, res_valid}), 64'(0));
  endtask

  initial begin
    int w;
    bit seen;
    int popped;
    int cyc;
    bit ga, gb, erv;
    bit m_inflight;
    bit m_last;
    int m_cnt;
    res_t r;
    logic [WIDTH:0] full;

    vt[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vt[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vt[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vt[3] = '{1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vt[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vt[5] = '{1'b1, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vt[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};

    // Reset values, with requests pending so the readies must stay low.
    rst_n = 1'b0;
    idle_inputs();
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    chk("rst res_valid", 64'(res_valid), 64'(0));
    chk("rst res_sum", 64'(res_sum), 64'(0));
    chk("rst res_cout", 64'(res_cout), 64'(0));
    chk("rst res_id", 64'(res_id), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst readies", 64'({a_ready, b_ready}), 64'(0));
    idle_inputs();
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_op(vt[i]);

    // Contention from reset release: A, B, A, B.
    rst_n = 1'b0;
    a_valid = 1'b1; a_x = 32'd5; a_y = 32'd6; a_cin = 1'b0;
    b_valid = 1'b1; b_x = 32'h100; b_y = 32'h200; b_cin = 1'b1;
    @(posedge clk1); #1;
    chk("cont readies in reset", 64'({a_ready, b_ready}), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("cont first grant", 64'({a_ready, b_ready}), 64'(2'b10));
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!res_valid && w < 30) begin
        @(posedge clk1); #1; w++;
      end
      chk("cont id", 64'(res_id), 64'(k % 2));
      chk("cont sum", 64'(res_sum), (k % 2 == 0) ? 64'd11 : 64'h301);
      if (k == 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      @(posedge clk1); #1;
    end
    chk("cont idle", 64'(busy), 64'(0));
    res_ready = 1'b0;

    // Backpressure: DONE held for 10 cycles with both requesters waiting.
    a_valid = 1'b1; a_x = 32'h0F0F_0F0F; a_y = 32'h0101_0101; a_cin = 1'b1;
    #1;
    chk("bp accept ready", 64'(a_ready), 64'(1));
    @(posedge clk1); #1;
    b_valid = 1'b1; b_x = 32'd7; b_y = 32'd8; b_cin = 1'b0;
    w = 0;
    while (!res_valid && w < 20) begin
      @(posedge clk1); #1; w++;
    end
    for (int k = 0; k < 10; k++) begin
      chk("bp res_valid", 64'(res_valid), 64'(1));
      chk("bp sum", 64'(res_sum), 64'h1010_1011);
      chk("bp readies", 64'({a_ready, b_ready}), 64'(0));
      @(posedge clk1); #1;
    end
    res_ready = 1'b1;
    @(posedge clk1); #1;
    res_ready = 1'b0;
    chk("bp release idle", 64'({busy, res_valid}), 64'(0));
    chk("bp next grant", 64'({a_ready, b_ready}), 64'(2'b01));
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk1); #1;

    // Reset while slice 2 is being computed.
    b_valid = 1'b1; b_x = 32'h1234_5678; b_y = 32'h1111_1111; b_cin = 1'b1;
    #1;
    chk("mid ready", 64'(b_ready), 64'(1));
    @(posedge clk1); #1;
    b_valid = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    chk("mid busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk1); #1;
    chk("mid rst outputs", 64'({res_valid, res_cout, res_id, busy}), 64'(0));
    chk("mid rst sum", 64'(res_sum), 64'(0));
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk1); #1;
      if (res_valid || busy) seen = 1'b1;
    end
    chk("mid no result", 64'(seen), 64'(0));

    // Randomized streams against the transaction-level model.
    do_reset();
    m_inflight = 1'b0;
    m_last = 1'b1;
    m_cnt = 0;
    popped = 0;
    cyc = 0;
    while (popped < 1000 && cyc < 60000) begin
      #4;
      erv = m_inflight && (m_cnt >= NSL);
      ga = !m_inflight && a_valid && (!b_valid || m_last);
      gb = !m_inflight && b_valid && (!a_valid || !m_last);
      chk("rnd a_ready", 64'(a_ready), 64'(ga));
      chk("rnd b_ready", 64'(b_ready), 64'(gb));
      chk("rnd res_valid", 64'(res_valid), 64'(erv));
      if (erv && exp_q.size() > 0) begin
        chk("rnd sum", 64'(res_sum), 64'(exp_q[0].sum));
        chk("rnd cout", 64'(res_cout), 64'(exp_q[0].cout));
        chk("rnd id", 64'(res_id), 64'(exp_q[0].id));
      end
      if (ga || gb) begin
        if (ga) full = {1'b0, a_x} + {1'b0, a_y} + (WIDTH+1)'(a_cin);
        else    full = {1'b0, b_x} + {1'b0, b_y} + (WIDTH+1)'(b_cin);
        r.sum = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.id = gb;
        exp_q.push_back(r);
        m_last = gb;
        m_inflight = 1'b1;
        m_cnt = 0;
      end else if (erv && res_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        popped++;
        m_inflight = 1'b0;
      end else if (m_inflight) begin
        m_cnt++;
      end
      @(posedge clk1); #1;
      cyc++;
      if (a_valid && !ga && $urandom_range(0, 15) == 0) begin
        a_valid = 1'b0;
      end else if (ga || !a_valid) begin
        a_valid = 1'($urandom_range(0, 1));
        a_x = rnd_word(); a_y = rnd_word(); a_cin = 1'($urandom_range(0, 1));
      end
      if (b_valid && !gb && $urandom_range(0, 15) == 0) begin
        b_valid = 1'b0;
      end else if (gb || !b_valid) begin
        b_valid = 1'($urandom_range(0, 1));
        b_x = rnd_word(); b_y = rnd_word(); b_cin = 1'($urandom_range(0, 1));
      end
      res_ready = ($urandom_range(0, 2) != 0);
    end
    chk("rnd completed ops", 64'(popped), 64'(1000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
